peri_charlieplex: RTL and testbench

PERI_CHARLIEPLEX -- requirements
Module: peri_charlieplex

---
 rtl/charlieplex_pkg.sv | 23 ++
 rtl/peri_charlieplex_if.sv | 32 +++
 rtl/charlieplex_drive.sv | 33 +++
 rtl/peri_charlieplex.sv | 179 +++++++++++++++++
 tb/tb_peri_charlieplex.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/charlieplex_pkg.sv
// Shared definitions for the charlieplexed LED scanner: scan states,
// register map addresses and the pin count.
package charlieplex_pkg;

    localparam int NumPins = 7;

    localparam int RowBase = 0;
    localparam int Ctrl    = 7;
    localparam int Dwell   = 8;
    localparam int Status  = 9;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        BLANK
    } scan_state_t;

    // Row sequencing wraps from the last row back to row 0.
    function automatic logic [2:0] next_row(input logic [2:0] row);
        return (row == 3'(NumPins - 1)) ? 3'd0 : row + 3'd1;
    endfunction

endpackage

// File: rtl/peri_charlieplex_if.sv
// Wishbone slave bus bundle for the charlieplex peripheral.
interface peri_charlieplex_if #(
    parameter int AddrW = 4,
    parameter int DataW = 8
);

    logic             wb_stb_i;
    logic             wb_we_i;
    logic [AddrW-1:0] wb_adr_i;
    logic [DataW-1:0] wb_dat_i;
    logic [DataW-1:0] wb_dat_o;
    logic             wb_ack_o;

    modport master (
        output wb_stb_i,
        output wb_we_i,
        output wb_adr_i,
        output wb_dat_i,
        input  wb_dat_o,
        input  wb_ack_o
    );

    modport slave (
        input  wb_stb_i,
        input  wb_we_i,
        input  wb_adr_i,
        input  wb_dat_i,
        output wb_dat_o,
        output wb_ack_o
    );

endinterface

// File: rtl/charlieplex_drive.sv
// Maps a row index and its 6-bit LED bitmap onto the 7 tri-state pins.
// The row pin sources current; each lit LED's column pin sinks it. Column
// numbering skips the row pin itself, so bit k lands on pin k below the row
// and pin k+1 at or above it.
module charlieplex_drive
    import charlieplex_pkg::*;
(
    input  logic [2:0]         row,
    input  logic [5:0]         bitmap,
    output logic [NumPins-1:0] pin_o,
    output logic [NumPins-1:0] pin_en
);

    // Build the pin pattern; an out-of-range row leaves every pin floating.
    always_comb begin
        pin_o  = '0;
        pin_en = '0;
        if (row < 3'(NumPins)) begin
            pin_o[row]  = 1'b1;
            pin_en[row] = 1'b1;
            for (int k = 0; k < 6; k++) begin
                if (bitmap[k]) begin
                    if (k < int'(row)) begin
                        pin_en[k] = 1'b1;
                    end else begin
                        pin_en[k+1] = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/peri_charlieplex.sv
// Charlieplexed 7-pin LED scanner with a Wishbone register interface.
// Holds the row bitmaps, control and dwell registers, and the scan FSM that
// walks the rows with a one-cycle blanking gap between them.
module peri_charlieplex
    import charlieplex_pkg::*;
#(
    parameter int AddrW      = 4,
    parameter int DataW      = 8,
    parameter int DwellShift = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    peri_charlieplex_if.slave  wb,
    output logic [NumPins-1:0] charlieplex_o,
    output logic [NumPins-1:0] charlieplex_en_o
);

    localparam int CntW = 8 + DwellShift;

    logic [AddrW-1:0]   adr;
    logic               bus_req;
    logic               ack_q;
    logic [DataW-1:0]   dat_q;
    logic [7:0]         rd_data;
    logic               adr_is_row;

    logic [5:0]         row_regs [NumPins];
    logic               ctrl_en;
    logic [7:0]         dwell_reg;

    scan_state_t        state;
    logic [2:0]         row_idx;
    logic [CntW-1:0]    dwell_cnt;
    logic [CntW-1:0]    dwell_load;
    logic [5:0]         shadow;

    logic [2:0]         entry_row;
    logic [2:0]         drv_row;
    logic [5:0]         drv_bits;
    logic [NumPins-1:0] drv_o;
    logic [NumPins-1:0] drv_en;

    assign adr          = wb.wb_adr_i;
    assign bus_req      = wb.wb_stb_i && !ack_q;
    assign adr_is_row   = (adr < AddrW'(NumPins));
    assign wb.wb_ack_o  = ack_q;
    assign wb.wb_dat_o  = dat_q;

    // Row on-time minus one: (DWELL + 1) << shift, less one for the down-counter.
    assign dwell_load = (CntW'(dwell_reg) << DwellShift)
                      | ((CntW'(1) << DwellShift) - CntW'(1));

    // A new row is entered from IDLE at row 0, or from BLANK at the following row.
    assign entry_row = (state == BLANK) ? next_row(row_idx) : 3'd0;

    // While driving, keep showing the latched shadow; otherwise preview the row about to start.
    always_comb begin
        drv_row  = entry_row;
        drv_bits = row_regs[entry_row];
        if (state == DRIVE) begin
            drv_row  = row_idx;
            drv_bits = shadow;
        end
    end

    charlieplex_drive u_drive (
        .row    (drv_row),
        .bitmap (drv_bits),
        .pin_o  (drv_o),
        .pin_en (drv_en)
    );

    // Register read multiplexer; unmapped addresses and unused bits read as zero.
    always_comb begin
        rd_data = 8'h00;
        if (adr_is_row) begin
            rd_data = {2'b00, row_regs[adr[2:0]]};
        end else if (adr == AddrW'(Ctrl)) begin
            rd_data = {7'b0, ctrl_en};
        end else if (adr == AddrW'(Dwell)) begin
            rd_data = dwell_reg;
        end else if (adr == AddrW'(Status)) begin
            rd_data = {(state != IDLE), 4'b0000, row_idx};
        end
    end

    // Bus side: single-cycle ack, write on the ack edge, read data captured on the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_q     <= 1'b0;
            dat_q     <= '0;
            row_regs  <= '{default: '0};
            ctrl_en   <= 1'b0;
            dwell_reg <= 8'h00;
        end else begin
            ack_q <= bus_req;
            dat_q <= bus_req ? DataW'(rd_data) : '0;
            if (bus_req && wb.wb_we_i) begin
                if (adr_is_row) begin
                    row_regs[adr[2:0]] <= wb.wb_dat_i[5:0];
                end else if (adr == AddrW'(Ctrl)) begin
                    ctrl_en <= wb.wb_dat_i[0];
                end else if (adr == AddrW'(Dwell)) begin
                    dwell_reg <= wb.wb_dat_i[7:0];
                end
            end
        end
    end

    // Scan FSM with registered pin outputs; disabling drops straight back to IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= IDLE;
            row_idx          <= 3'd0;
            dwell_cnt        <= '0;
            shadow           <= 6'd0;
            charlieplex_o    <= '0;
            charlieplex_en_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    row_idx          <= 3'd0;
                    dwell_cnt        <= '0;
                    charlieplex_o    <= '0;
                    charlieplex_en_o <= '0;
                    if (ctrl_en) begin
                        state            <= DRIVE;
                        row_idx          <= entry_row;
                        shadow           <= drv_bits;
                        dwell_cnt        <= dwell_load;
                        charlieplex_o    <= drv_o;
                        charlieplex_en_o <= drv_en;
                    end
                end
                DRIVE: begin
                    if (!ctrl_en) begin
                        state            <= IDLE;
                        row_idx          <= 3'd0;
                        dwell_cnt        <= '0;
                        charlieplex_o    <= '0;
                        charlieplex_en_o <= '0;
                    end else if (dwell_cnt == '0) begin
                        state            <= BLANK;
                        charlieplex_o    <= '0;
                        charlieplex_en_o <= '0;
                    end else begin
                        dwell_cnt        <= dwell_cnt - CntW'(1);
                        charlieplex_o    <= drv_o;
                        charlieplex_en_o <= drv_en;
                    end
                end
                BLANK: begin
                    if (!ctrl_en) begin
                        state            <= IDLE;
                        row_idx          <= 3'd0;
                        dwell_cnt        <= '0;
                        charlieplex_o    <= '0;
                        charlieplex_en_o <= '0;
                    end else begin
                        state            <= DRIVE;
                        row_idx          <= entry_row;
                        shadow           <= drv_bits;
                        dwell_cnt        <= dwell_load;
                        charlieplex_o    <= drv_o;
                        charlieplex_en_o <= drv_en;
                    end
                end
                default: begin
                    state            <= IDLE;
                    row_idx          <= 3'd0;
                    dwell_cnt        <= '0;
                    charlieplex_o    <= '0;
                    charlieplex_en_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_peri_charlieplex.sv
// Directed bench for peri_charlieplex: register access, row timing and
// patterns, shadow latching, disable, held strobe, frame wrap and reset abort.
module tb_peri_charlieplex;

    localparam int RunLimit = 1000;

    logic       clk;
    logic       rst;
    logic [6:0] pin_o;
    logic [6:0] pin_en;

    int checks   = 0;
    int failures = 0;

    logic [7:0] rdat;
    int         run_n;
    logic [6:0] run_en;
    logic [6:0] run_o;

    peri_charlieplex_if #(.AddrW(4), .DataW(8)) wb ();

    peri_charlieplex #(.AddrW(4), .DataW(8), .DwellShift(8)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .wb               (wb),
        .charlieplex_o    (pin_o),
        .charlieplex_en_o (pin_en)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Never more than one pin may source current at once.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            assert ($countones(pin_o & pin_en) <= 1)
            else begin
                failures++;
                $error("[TB] FAIL one_source: observed o=0x%0h en=0x%0h expected at most one driven-high pin",
                       pin_o, pin_en);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wb_xfer(input string tag, input logic we, input logic [3:0] adr,
                           input logic [7:0] wdat, output logic [7:0] rd);
        wb.wb_we_i  = we;
        wb.wb_adr_i = adr;
        wb.wb_dat_i = wdat;
        check({tag, "_ack_pre"}, 32'(wb.wb_ack_o), 32'd0);
        wb.wb_stb_i = 1'b1;
        tick();
        check({tag, "_ack"}, 32'(wb.wb_ack_o), 32'd1);
        rd = wb.wb_dat_o;
        wb.wb_stb_i = 1'b0;
        wb.wb_we_i  = 1'b0;
        tick();
        check({tag, "_ack_drop"}, 32'(wb.wb_ack_o), 32'd0);
    endtask

    // Length of the current constant pin pattern; leaves us on the first sample of the next one.
    task automatic count_run(input string tag, output int n, output logic [6:0] en_s, output logic [6:0] o_s);
        logic stop;
        logic timeout;
        en_s    = pin_en;
        o_s     = pin_o;
        n       = 1;
        stop    = 1'b0;
        timeout = 1'b0;
        while (!stop) begin
            tick();
            if (pin_en !== en_s || pin_o !== o_s) begin
                stop = 1'b1;
            end else begin
                n++;
                if (n > RunLimit) begin
                    timeout = 1'b1;
                    stop    = 1'b1;
                end
            end
        end
        check({tag, "_timeout"}, 32'(timeout), 32'd0);
    endtask

    // One driven row of the expected pattern and length, followed by a single blank cycle.
    task automatic check_row(input string tag, input logic [6:0] en_exp, input logic [6:0] o_exp, input int len_exp);
        int         n;
        logic [6:0] en_s;
        logic [6:0] o_s;
        count_run(tag, n, en_s, o_s);
        check({tag, "_en"}, 32'(en_s), 32'(en_exp));
        check({tag, "_o"}, 32'(o_s), 32'(o_exp));
        check({tag, "_len"}, 32'(n), 32'(len_exp));
        count_run({tag, "_blank"}, n, en_s, o_s);
        check({tag, "_blank_en"}, 32'(en_s), 32'd0);
        check({tag, "_blank_o"}, 32'(o_s), 32'd0);
        check({tag, "_blank_len"}, 32'(n), 32'd1);
    endtask

    initial begin
        rst         = 1'b1;
        wb.wb_stb_i = 1'b0;
        wb.wb_we_i  = 1'b0;
        wb.wb_adr_i = 4'd0;
        wb.wb_dat_i = 8'd0;

        // Reset state.
        tick(); tick(); tick();
        check("rst_ack", 32'(wb.wb_ack_o), 32'd0);
        check("rst_dat", 32'(wb.wb_dat_o), 32'd0);
        check("rst_en", 32'(pin_en), 32'd0);
        check("rst_o", 32'(pin_o), 32'd0);
        rst = 1'b0;

        wb_xfer("rd_status0", 1'b0, 4'd9, 8'h00, rdat);
        check("rd_status0_dat", 32'(rdat), 32'h00);
        check("idle_en", 32'(pin_en), 32'd0);
        check("idle_o", 32'(pin_o), 32'd0);

        // Register readback, unused bits and unmapped addresses.
        wb_xfer("wr_row0", 1'b1, 4'd0, 8'hFF, rdat);
        wb_xfer("rd_row0", 1'b0, 4'd0, 8'h00, rdat);
        check("rd_row0_dat", 32'(rdat), 32'h3F);
        wb_xfer("wr_a13", 1'b1, 4'd13, 8'h55, rdat);
        wb_xfer("rd_a13", 1'b0, 4'd13, 8'h00, rdat);
        check("rd_a13_dat", 32'(rdat), 32'h00);
        wb_xfer("wr_dwell", 1'b1, 4'd8, 8'hA5, rdat);
        wb_xfer("rd_dwell", 1'b0, 4'd8, 8'h00, rdat);
        check("rd_dwell_dat", 32'(rdat), 32'hA5);
        wb_xfer("wr_dwell0", 1'b1, 4'd8, 8'h00, rdat);
        wb_xfer("rd_ctrl", 1'b0, 4'd7, 8'h00, rdat);
        check("rd_ctrl_dat", 32'(rdat), 32'h00);
        wb_xfer("wr_row0_clr", 1'b1, 4'd0, 8'h00, rdat);
        wb_xfer("wr_row2", 1'b1, 4'd2, 8'h05, rdat);
        wb_xfer("rd_row2", 1'b0, 4'd2, 8'h00, rdat);
        check("rd_row2_dat", 32'(rdat), 32'h05);

        // Start scanning: row 0 begins on the edge after the CTRL write.
        wb_xfer("wr_ctrl1", 1'b1, 4'd7, 8'h01, rdat);
        check_row("row0", 7'h01, 7'h01, 256);
        check_row("row1", 7'h02, 7'h02, 256);
        check("row2_en", 32'(pin_en), 32'h0D);
        check("row2_o", 32'(pin_o), 32'h04);

        // Status while driving row 2, then a mid-row rewrite that must not show yet.
        wb_xfer("rd_status2", 1'b0, 4'd9, 8'h00, rdat);
        check("rd_status2_dat", 32'(rdat), 32'h82);
        wb_xfer("wr_row2_ff", 1'b1, 4'd2, 8'h3F, rdat);
        check("row2_hold_en", 32'(pin_en), 32'h0D);
        check("row2_hold_o", 32'(pin_o), 32'h04);
        check_row("row2_rest", 7'h0D, 7'h04, 252);

        // Held strobe on an unmapped address during row 3.
        wb.wb_we_i  = 1'b0;
        wb.wb_adr_i = 4'd12;
        wb.wb_stb_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("held_ack%0d", i), 32'(wb.wb_ack_o), 32'(i % 2));
            if (i % 2 == 1) begin
                check($sformatf("held_dat%0d", i), 32'(wb.wb_dat_o), 32'h00);
            end
            tick();
        end
        wb.wb_stb_i = 1'b0;
        check_row("row3", 7'h08, 7'h08, 250);
        check_row("row4", 7'h10, 7'h10, 256);
        check_row("row5", 7'h20, 7'h20, 256);
        check_row("row6", 7'h40, 7'h40, 256);
        check_row("row0b", 7'h01, 7'h01, 256);
        check_row("row1b", 7'h02, 7'h02, 256);
        check_row("row2_new", 7'h7F, 7'h04, 256);
        check_row("row3b", 7'h08, 7'h08, 256);

        // Disable mid-row 4: pins still lit on the write edge, dark on the next.
        for (int i = 0; i < 5; i++) tick();
        wb.wb_we_i  = 1'b1;
        wb.wb_adr_i = 4'd7;
        wb.wb_dat_i = 8'h00;
        wb.wb_stb_i = 1'b1;
        tick();
        check("dis_ack", 32'(wb.wb_ack_o), 32'd1);
        check("dis_still_en", 32'(pin_en), 32'h10);
        wb.wb_stb_i = 1'b0;
        wb.wb_we_i  = 1'b0;
        tick();
        check("dis_en", 32'(pin_en), 32'h00);
        check("dis_o", 32'(pin_o), 32'h00);
        wb_xfer("rd_status_dis", 1'b0, 4'd9, 8'h00, rdat);
        check("rd_status_dis_dat", 32'(rdat), 32'h00);

        // Full frame with every LED lit, including the row 6 to row 0 wrap.
        for (int r = 0; r < 7; r++) begin
            wb_xfer($sformatf("wr_full%0d", r), 1'b1, 4'(r), 8'h3F, rdat);
        end
        wb_xfer("wr_ctrl1b", 1'b1, 4'd7, 8'h01, rdat);
        for (int r = 0; r < 7; r++) begin
            check_row($sformatf("full%0d", r), 7'h7F, 7'(1 << r), 256);
        end
        check("wrap_en", 32'(pin_en), 32'h7F);
        check("wrap_o", 32'(pin_o), 32'h01);

        // DWELL change mid-row applies from the next row entry.
        wb_xfer("wr_dwell1", 1'b1, 4'd8, 8'h01, rdat);
        check_row("dw_row0", 7'h7F, 7'h01, 254);
        check_row("dw_row1", 7'h7F, 7'h02, 512);

        // Reset mid-row with a strobe pending: no ack, everything cleared.
        rst         = 1'b1;
        wb.wb_we_i  = 1'b0;
        wb.wb_adr_i = 4'd9;
        wb.wb_stb_i = 1'b1;
        tick();
        check("rst2_ack", 32'(wb.wb_ack_o), 32'd0);
        check("rst2_dat", 32'(wb.wb_dat_o), 32'd0);
        check("rst2_en", 32'(pin_en), 32'd0);
        check("rst2_o", 32'(pin_o), 32'd0);
        tick();
        check("rst2_ack_b", 32'(wb.wb_ack_o), 32'd0);
        rst         = 1'b0;
        wb.wb_stb_i = 1'b0;
        tick();
        check("rst2_ack_after", 32'(wb.wb_ack_o), 32'd0);
        check("rst2_en_after", 32'(pin_en), 32'd0);
        wb_xfer("rd_status_r", 1'b0, 4'd9, 8'h00, rdat);
        check("rd_status_r_dat", 32'(rdat), 32'h00);
        wb_xfer("rd_row2_r", 1'b0, 4'd2, 8'h00, rdat);
        check("rd_row2_r_dat", 32'(rdat), 32'h00);
        wb_xfer("rd_dwell_r", 1'b0, 4'd8, 8'h00, rdat);
        check("rd_dwell_r_dat", 32'(rdat), 32'h00);
        wb_xfer("rd_ctrl_r", 1'b0, 4'd7, 8'h00, rdat);
        check("rd_ctrl_r_dat", 32'(rdat), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
